// File: rtl/spi_clk_pkg.sv
// Shared types and widths for the SPI clock/reset sequencer.
// The state encodings are visible on state_o for VIO/ILA use, so keep them stable.
package spi_clk_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_MMCM_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // Larger of two integers, used to size the shared timer at elaboration time.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
    return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LOSS_W-1:0] loss_inc(input logic [LOSS_W-1:0] v);
    return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/spi_clock_reset_sequencer_lock_sync_filter.sv
// Brings the asynchronous MMCM LOCKED into the oscillator domain and counts
// how many consecutive cycles the synchronised value has been high.
// lk_stable fires on the cycle that completes FILTER_CYCLES consecutive highs.
module lock_sync_filter
  import spi_clk_pkg::*;
#(
  parameter int FILTER_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic locked_async,
  output logic lk,
  output logic lk_stable
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic             meta;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; both stages start low so lock is never assumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      lk   <= 1'b0;
    end else begin
      meta <= locked_async;
      lk   <= meta;
    end
  end

  // Consecutive-high counter; any low cycle or a clear request restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || !lk) begin
      cnt <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign lk_stable = lk && (cnt == CNT_LAST);

endmodule

// File: rtl/spi_clock_reset_sequencer.sv
// Clock/reset sequencer beside the MMCM: pulses the MMCM reset, waits for a
// filtered lock, releases NUM_RST reset domains in staggered order, and
// re-runs the sequence on lock loss with a bounded number of retries.
module spi_clock_reset_sequencer
  import spi_clk_pkg::*;
#(
  parameter int NUM_RST             = 4,
  parameter int MMCM_RST_CYCLES     = 8,
  parameter int LOCK_FILTER_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int STAGGER_CYCLES      = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               osc_clk_i,
  input  logic               fpga_rst_n_i,
  input  logic               mmcm_locked_i,
  output logic               mmcm_rst_o,
  output logic [NUM_RST-1:0] reset_n_o,
  output logic               clock_good_o,
  output logic               fault_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [LOSS_W-1:0]  lock_loss_cnt_o,
  output logic [STATE_W-1:0] state_o
);

  // One timer serves the MMCM reset pulse, the lock timeout and the stagger,
  // since only one of them is ever running.
  localparam int REL_SPAN = STAGGER_CYCLES * (NUM_RST - 1);
  localparam int TMR_MAX  = max_int(max_int(MMCM_RST_CYCLES, LOCK_TIMEOUT_CYCLES), REL_SPAN);
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]   RST_LAST     = TMR_W'(MMCM_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]   REL_LAST     = TMR_W'(REL_SPAN);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W:0]     tmr_inc;
  logic [NUM_RST-1:0] release_mask;
  logic               lk;
  logic               lk_stable;
  logic               filt_clear;
  logic               lock_lost;

  lock_sync_filter #(
    .FILTER_CYCLES(LOCK_FILTER_CYCLES)
  ) u_lock_sync_filter (
    .clk         (osc_clk_i),
    .rst_n       (fpga_rst_n_i),
    .clear       (filt_clear),
    .locked_async(mmcm_locked_i),
    .lk          (lk),
    .lk_stable   (lk_stable)
  );

  // The consecutive-lock count only means something while filtering.
  assign filt_clear = (state != ST_FILTER);
  assign lock_lost  = !lk && ((state == ST_RELEASE) || (state == ST_RUN));
  assign tmr_inc    = {1'b0, timer} + (TMR_W + 1)'(1);
  assign state_o    = state;

  // Domains whose release time has been reached once the timer advances;
  // bit i becomes due i*STAGGER_CYCLES cycles after the first release cycle.
  always_comb begin
    release_mask = '0;
    for (int i = 0; i < NUM_RST; i++) begin
      release_mask[i] = (int'(tmr_inc) >= i * STAGGER_CYCLES);
    end
  end

  // Sequencer FSM; every output is registered so resets assert on one edge.
  always_ff @(posedge osc_clk_i) begin
    if (!fpga_rst_n_i) begin
      state           <= ST_MMCM_RST;
      timer           <= '0;
      mmcm_rst_o      <= 1'b1;
      reset_n_o       <= '0;
      clock_good_o    <= 1'b0;
      fault_o         <= 1'b0;
      retry_cnt_o     <= '0;
      lock_loss_cnt_o <= '0;
    end else if (lock_lost) begin
      state           <= ST_MMCM_RST;
      timer           <= '0;
      mmcm_rst_o      <= 1'b1;
      reset_n_o       <= '0;
      clock_good_o    <= 1'b0;
      retry_cnt_o     <= '0;
      lock_loss_cnt_o <= loss_inc(lock_loss_cnt_o);
    end else begin
      case (state)
        ST_MMCM_RST: begin
          mmcm_rst_o   <= 1'b1;
          reset_n_o    <= '0;
          clock_good_o <= 1'b0;
          if (timer == RST_LAST) begin
            state      <= ST_WAIT_LOCK;
            mmcm_rst_o <= 1'b0;
            timer      <= '0;
          end else begin
            timer <= tmr_inc[TMR_W-1:0];
          end
        end
        ST_WAIT_LOCK: begin
          if (lk) begin
            state <= ST_FILTER;
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            timer <= '0;
            if (retry_cnt_o < RETRY_LIMIT) begin
              state       <= ST_MMCM_RST;
              mmcm_rst_o  <= 1'b1;
              retry_cnt_o <= retry_inc(retry_cnt_o);
            end else begin
              state   <= ST_FAULT;
              fault_o <= 1'b1;
            end
          end else begin
            timer <= tmr_inc[TMR_W-1:0];
          end
        end
        ST_FILTER: begin
          if (!lk) begin
            state <= ST_WAIT_LOCK;
            timer <= '0;
          end else if (lk_stable) begin
            state     <= ST_RELEASE;
            reset_n_o <= NUM_RST'(1);
            timer     <= '0;
          end
        end
        ST_RELEASE: begin
          reset_n_o <= release_mask;
          if (timer == REL_LAST) begin
            state        <= ST_RUN;
            clock_good_o <= 1'b1;
            timer        <= '0;
          end else begin
            timer <= tmr_inc[TMR_W-1:0];
          end
        end
        ST_RUN: begin
          clock_good_o <= 1'b1;
        end
        ST_FAULT: begin
          fault_o      <= 1'b1;
          mmcm_rst_o   <= 1'b0;
          reset_n_o    <= '0;
          clock_good_o <= 1'b0;
        end
        default: begin
          state        <= ST_MMCM_RST;
          timer        <= '0;
          mmcm_rst_o   <= 1'b1;
          reset_n_o    <= '0;
          clock_good_o <= 1'b0;
          fault_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_clock_reset_sequencer.sv
// Bench for spi_clock_reset_sequencer: expected reset/clock_good transitions
// and MMCM reset pulses are queued as stimulus is applied and compared by a
// monitor when the DUT changes them.
module tb_spi_clock_reset_sequencer;

  localparam int NUM_RST  = 3;
  localparam int RST_CYC  = 4;
  localparam int FILT_CYC = 8;
  localparam int TOUT_CYC = 32;
  localparam int STAG_CYC = 5;
  localparam int MAX_RTY  = 2;

  logic               clk = 1'b0;
  logic               fpga_rst_n;
  logic               mmcm_locked;
  logic               mmcm_rst_o;
  logic [NUM_RST-1:0] reset_n_o;
  logic               clock_good_o;
  logic               fault_o;
  logic [3:0]         retry_cnt_o;
  logic [7:0]         lock_loss_cnt_o;
  logic [2:0]         state_o;

  typedef struct {
    logic [3:0] val;
    int         at;
  } rel_ev_t;

  typedef struct {
    int         at;
    int         width;
    logic [3:0] retry;
  } pulse_ev_t;

  rel_ev_t    rel_q[$];
  pulse_ev_t  pulse_q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  logic [3:0] last_rel;
  logic       last_mmcm;
  int         rise_at = 0;

  spi_clock_reset_sequencer #(
    .NUM_RST            (NUM_RST),
    .MMCM_RST_CYCLES    (RST_CYC),
    .LOCK_FILTER_CYCLES (FILT_CYC),
    .LOCK_TIMEOUT_CYCLES(TOUT_CYC),
    .STAGGER_CYCLES     (STAG_CYC),
    .MAX_RETRIES        (MAX_RTY)
  ) dut (
    .osc_clk_i      (clk),
    .fpga_rst_n_i   (fpga_rst_n),
    .mmcm_locked_i  (mmcm_locked),
    .mmcm_rst_o     (mmcm_rst_o),
    .reset_n_o      (reset_n_o),
    .clock_good_o   (clock_good_o),
    .fault_o        (fault_o),
    .retry_cnt_o    (retry_cnt_o),
    .lock_loss_cnt_o(lock_loss_cnt_o),
    .state_o        (state_o)
  );

  // Free-running oscillator, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Edge counter used to timestamp every expected and observed event.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic locked);
    fpga_rst_n  = rst_n;
    mmcm_locked = locked;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pushRel(input logic [3:0] val, input int at);
    rel_ev_t e;
    e.val = val;
    e.at  = at;
    rel_q.push_back(e);
  endtask

  task automatic pushPulse(input int at, input int width, input logic [3:0] retry);
    pulse_ev_t e;
    e.at    = at;
    e.width = width;
    e.retry = retry;
    pulse_q.push_back(e);
  endtask

  // Full staggered release starting at cycle r: 001, 011, 111, then clock_good.
  task automatic pushRelease(input int r);
    pushRel(4'b0001, r);
    pushRel(4'b0011, r + STAG_CYC);
    pushRel(4'b0111, r + 2 * STAG_CYC);
    pushRel(4'b1111, r + 2 * STAG_CYC + 1);
  endtask

  // Monitor: pop and compare expectations whenever a watched output changes.
  always @(negedge clk) begin
    if (mon_en) begin
      if ({clock_good_o, reset_n_o} !== last_rel) begin
        if (rel_q.size() == 0) begin
          checkOutput("rel_unexpected", 32'(rel_q.size()), 32'd1);
        end else begin
          checkOutput("rel_value", 32'({clock_good_o, reset_n_o}), 32'(rel_q[0].val));
          checkOutput("rel_cycle", cyc, rel_q[0].at);
          void'(rel_q.pop_front());
        end
      end
      if (mmcm_rst_o && !last_mmcm) rise_at <= cyc;
      if (!mmcm_rst_o && last_mmcm) begin
        if (pulse_q.size() == 0) begin
          checkOutput("pulse_unexpected", 32'(pulse_q.size()), 32'd1);
        end else begin
          checkOutput("pulse_fall_cycle", cyc, pulse_q[0].at);
          checkOutput("pulse_retry_cnt", 32'(retry_cnt_o), 32'(pulse_q[0].retry));
          if (pulse_q[0].width >= 0) checkOutput("pulse_width", cyc - rise_at, pulse_q[0].width);
          void'(pulse_q.pop_front());
        end
      end
    end
    last_rel  <= {clock_good_o, reset_n_o};
    last_mmcm <= mmcm_rst_o;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, l, d, r;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset values
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_mmcm_rst", 32'(mmcm_rst_o), 32'd1);
    checkOutput("rst_reset_n", 32'(reset_n_o), 32'd0);
    checkOutput("rst_clock_good", 32'(clock_good_o), 32'd0);
    checkOutput("rst_fault", 32'(fault_o), 32'd0);
    checkOutput("rst_retry", 32'(retry_cnt_o), 32'd0);
    checkOutput("rst_loss", 32'(lock_loss_cnt_o), 32'd0);
    mon_en = 1'b1;

    // Nominal bring-up: locked rises 10 cycles after reset release
    c0 = cyc;
    applyStimulus(1'b1, 1'b0);
    pushPulse(c0 + RST_CYC, -1, 4'd0);
    waitUntil(c0 + 10);
    applyStimulus(1'b1, 1'b1);
    l = cyc;
    pushRelease(l + 3 + FILT_CYC);
    waitUntil(l + 30);
    checkOutput("nom_state_run", 32'(state_o), 32'd4);
    checkOutput("nom_retry", 32'(retry_cnt_o), 32'd0);
    checkOutput("nom_loss", 32'(lock_loss_cnt_o), 32'd0);

    // Lock loss in RUN for 3 cycles, then full re-release
    d = cyc;
    applyStimulus(1'b1, 1'b0);
    pushRel(4'b0000, d + 3);
    pushPulse(d + 3 + RST_CYC, RST_CYC, 4'd0);
    waitUntil(d + 3);
    applyStimulus(1'b1, 1'b1);
    checkOutput("loss_cnt_1", 32'(lock_loss_cnt_o), 32'd1);
    checkOutput("loss_state", 32'(state_o), 32'd0);
    pushRelease(d + 3 + RST_CYC + 1 + FILT_CYC);
    waitUntil(d + 40);
    checkOutput("loss_rerun", 32'(state_o), 32'd4);

    // Reset asserted mid-RELEASE right after reset_n_o=001
    d = cyc;
    applyStimulus(1'b1, 1'b0);
    pushRel(4'b0000, d + 3);
    pushPulse(d + 3 + RST_CYC, RST_CYC, 4'd0);
    waitUntil(d + 3);
    applyStimulus(1'b1, 1'b1);
    pushRel(4'b0001, d + 16);
    waitUntil(d + 16);
    checkOutput("mid_loss_2", 32'(lock_loss_cnt_o), 32'd2);
    applyStimulus(1'b0, 1'b0);
    pushRel(4'b0000, d + 17);
    waitUntil(d + 17);
    checkOutput("mid_state", 32'(state_o), 32'd0);
    checkOutput("mid_mmcm_rst", 32'(mmcm_rst_o), 32'd1);
    checkOutput("mid_loss_clr", 32'(lock_loss_cnt_o), 32'd0);
    checkOutput("mid_retry", 32'(retry_cnt_o), 32'd0);
    checkOutput("mid_fault", 32'(fault_o), 32'd0);
    waitUntil(d + 19);

    // Glitchy lock: 5 high, 1 low, then stable
    c0 = cyc;
    applyStimulus(1'b1, 1'b0);
    pushPulse(c0 + RST_CYC, -1, 4'd0);
    waitUntil(c0 + 10);
    applyStimulus(1'b1, 1'b1);
    l = cyc;
    waitUntil(l + 5);
    applyStimulus(1'b1, 1'b0);
    waitUntil(l + 6);
    applyStimulus(1'b1, 1'b1);
    pushRelease(l + 6 + 3 + FILT_CYC);
    waitUntil(l + 7);
    checkOutput("glitch_filter", 32'(state_o), 32'd2);
    waitUntil(l + 8);
    checkOutput("glitch_wait", 32'(state_o), 32'd1);
    checkOutput("glitch_retry", 32'(retry_cnt_o), 32'd0);
    waitUntil(l + 40);
    checkOutput("glitch_run", 32'(state_o), 32'd4);

    // Timeout and retry ending in FAULT
    r = cyc;
    applyStimulus(1'b0, 1'b0);
    pushRel(4'b0000, r + 1);
    waitUntil(r + 2);
    c0 = cyc;
    applyStimulus(1'b1, 1'b0);
    pushPulse(c0 + RST_CYC, -1, 4'd0);
    pushPulse(c0 + 2 * RST_CYC + TOUT_CYC, RST_CYC, 4'd1);
    pushPulse(c0 + 3 * RST_CYC + 2 * TOUT_CYC, RST_CYC, 4'd2);
    waitUntil(c0 + 3 * RST_CYC + 3 * TOUT_CYC - 1);
    checkOutput("tout_last_wait", 32'(state_o), 32'd1);
    checkOutput("tout_no_fault", 32'(fault_o), 32'd0);
    waitUntil(c0 + 3 * RST_CYC + 3 * TOUT_CYC);
    checkOutput("fault_flag", 32'(fault_o), 32'd1);
    checkOutput("fault_state", 32'(state_o), 32'd5);
    checkOutput("fault_mmcm_rst", 32'(mmcm_rst_o), 32'd0);
    checkOutput("fault_reset_n", 32'(reset_n_o), 32'd0);
    checkOutput("fault_retry", 32'(retry_cnt_o), 32'd2);
    waitUntil(c0 + 3 * RST_CYC + 3 * TOUT_CYC + 2);
    applyStimulus(1'b1, 1'b1);
    waitUntil(c0 + 3 * RST_CYC + 3 * TOUT_CYC + 200);
    checkOutput("fault_hold_state", 32'(state_o), 32'd5);
    checkOutput("fault_hold_flag", 32'(fault_o), 32'd1);
    checkOutput("fault_hold_rst_n", 32'(reset_n_o), 32'd0);
    checkOutput("fault_hold_mmcm", 32'(mmcm_rst_o), 32'd0);
    r = cyc;
    applyStimulus(1'b0, 1'b0);
    waitUntil(r + 1);
    checkOutput("unfault_state", 32'(state_o), 32'd0);
    checkOutput("unfault_flag", 32'(fault_o), 32'd0);
    checkOutput("unfault_mmcm", 32'(mmcm_rst_o), 32'd1);
    waitUntil(r + 3);

    // Saturation: 260 lock losses, each dropped on the first RELEASE cycle
    mon_en = 1'b0;
    c0 = cyc;
    applyStimulus(1'b1, 1'b0);
    waitUntil(c0 + 10);
    applyStimulus(1'b1, 1'b1);
    d = c0 + 10 + 3 + FILT_CYC;
    for (int k = 0; k < 260; k++) begin
      waitUntil(d);
      applyStimulus(1'b1, 1'b0);
      waitUntil(d + 3);
      applyStimulus(1'b1, 1'b1);
      if (k == 99) checkOutput("sat_loss_100", 32'(lock_loss_cnt_o), 32'd100);
      if (k == 254) checkOutput("sat_loss_255", 32'(lock_loss_cnt_o), 32'd255);
      d = d + 3 + RST_CYC + 1 + FILT_CYC;
    end
    waitUntil(d + 5);
    checkOutput("sat_loss_hold", 32'(lock_loss_cnt_o), 32'd255);

    checkOutput("rel_q_left", 32'(rel_q.size()), 32'd0);
    checkOutput("pulse_q_left", 32'(pulse_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
